// File: rtl/fifo_pkg.sv
// Shared definitions for the 36-bit sync FIFO and its stream reader.
// Holds FIFO geometry, the word type and the 2-entry buffer occupancy helper.
package fifo_pkg;

  localparam int FIFO_WIDTH = 36;
  localparam int FIFO_DEPTH = 512;
  localparam int FIFO_PTR_W = 10;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

  // Occupancy after one cycle of simultaneous push/pop; both together leave it unchanged.
  function automatic logic [1:0] next_count(input logic [1:0] count,
                                            input logic       push,
                                            input logic       pop);
    return count + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry circular word store with registered head, tail and occupancy.
// head_data always shows the oldest word, so it stays put until that word is popped.
module skid_buffer2
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= next_count(count, push, pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the sync FIFO into a valid/ready stream, hiding its one-cycle read latency.
// Optional accepted-word counter port word_count is built when FIFO_READER_STATS_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]      word_count
`endif
);

  logic [1:0] count;
  logic       inflight;
  logic       deq;
  logic [2:0] occupancy;

  assign deq = m_valid && m_ready;

  // Words held plus words already requested, after this cycle's dequeue; never exceeds two.
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_rd_en = rst_n && !fifo_empty && (occupancy <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      m_valid  <= (next_count(count, inflight, deq) != 2'd0);
    end
  end

  skid_buffer2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (deq),
    .count    (count),
    .head_data(m_data)
  );

`ifdef FIFO_READER_STATS_EN
  logic [31:0] stat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= 32'd0;
    end else if (deq) begin
      stat_count <= stat_count + 32'd1;
    end
  end

  assign word_count = stat_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model with registered read data,
// scoreboard of written words, and directed steps including backpressure and reset.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_rd_en;
  logic       fifo_empty = 1'b1;
  fifo_word_t fifo_rd_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  fifo_word_t m_data;
`ifdef FIFO_READER_STATS_EN
  logic [31:0] word_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int popCount = 0;
  int handshakes = 0;
  int lastHsCyc = 0;
  int prevHsCyc = 0;
  logic prevStall = 1'b0;
  fifo_word_t prevData = '0;

  fifo_word_t fifoQ[$];
  fifo_word_t writeQ[$];
  fifo_word_t expQ[$];

  fifo_stream_reader #(
    .WIDTH(FIFO_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_count  (word_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input fifo_word_t w);
    writeQ.push_back(w);
    expQ.push_back(w);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    expQ.delete();
    writeQ.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drainAll(input string tag, input int limit);
    int n = 0;
    while ((expQ.size() != 0 || m_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
  endtask

  // Sync FIFO model sharing the reader's reset: read data is registered one cycle after the pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifoQ.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_rd_en && !fifo_empty) fifo_rd_data <= fifoQ.pop_front();
      while (writeQ.size() > 0) fifoQ.push_back(writeQ.pop_front());
      fifo_empty <= (fifoQ.size() == 0);
    end
  end

  // Output monitor: scoreboard order, hold-while-stalled and buffer occupancy bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("count_le_2", 64'(dut.u_buf.count <= 2'd2), 64'd1);
      if (fifo_rd_en && !fifo_empty) popCount++;
      if (prevStall) begin
        checkOutput("stall_valid_held", 64'(m_valid), 64'd1);
        checkOutput("stall_data_held", 64'(m_data), 64'(prevData));
      end
      if (m_valid && m_ready) begin
        checkOutput("sb_word", 64'(m_data), (expQ.size() > 0) ? 64'(expQ.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF);
        handshakes++;
        prevHsCyc = lastHsCyc;
        lastHsCyc = cyc;
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
    end
  end

  initial begin
    int popCyc;
    int p0;
    int hsBase;
    int written;
    bit found;
    logic [63:0] r;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_data", 64'(m_data), 64'd0);
    checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Four words streamed with the consumer always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(fifo_word_t'(i));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = fifo_rd_en;
    end
    checkOutput("t1_first_pop", 64'(found), 64'd1);
    popCyc = cyc;
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    checkOutput("t1_latency", 64'(cyc - popCyc), 64'd2);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t1_back_to_back", 64'(m_valid && m_ready), 64'd1);
      @(negedge clk);
    end
    checkOutput("t1_rd_en_idle", 64'(fifo_rd_en), 64'd0);
    checkOutput("t1_valid_idle", 64'(m_valid), 64'd0);

    // Backpressure: only two words may leave the FIFO
    @(posedge clk);
    #1 m_ready = 1'b0;
    p0 = popCount;
    for (int i = 0; i < 10; i++) applyStimulus(fifo_word_t'(36'h100 + i));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) checkOutput("t2_hold_word0", 64'(m_data), 64'h100);
    end
    checkOutput("t2_pops", 64'(popCount - p0), 64'd2);
    checkOutput("t2_valid", 64'(m_valid), 64'd1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    drainAll("t2", 100);

    // Second word arrives the cycle after the first pop
    @(posedge clk);
    #1 applyStimulus(36'hA_AAAA_0001);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = fifo_rd_en;
    end
    checkOutput("t3_first_pop", 64'(found), 64'd1);
    @(posedge clk);
    #1 applyStimulus(36'hB_BBBB_0002);
    drainAll("t3", 50);
    checkOutput("t3_gap_le_2", 64'((lastHsCyc - prevHsCyc) <= 2), 64'd1);

    // Random ready and random writes
    hsBase = handshakes;
    written = 0;
    for (int c = 0; c < 60000 && (written < 10000 || expQ.size() != 0); c++) begin
      @(posedge clk);
      #1;
      m_ready = 1'($urandom_range(0, 1));
      if (written < 10000 && $urandom_range(0, 9) < 6) begin
        r = {$urandom(), $urandom()};
        applyStimulus(r[35:0]);
        written++;
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    drainAll("t4", 100);
    checkOutput("t4_word_total", 64'(handshakes - hsBase), 64'd10000);

    // Reset while the buffer is full
    @(posedge clk);
    #1 m_ready = 1'b0;
    p0 = popCount;
    for (int i = 0; i < 5; i++) applyStimulus(fifo_word_t'(36'h500 + i));
    repeat (6) @(negedge clk);
    checkOutput("t5_pre_pops", 64'(popCount - p0), 64'd2);
    checkOutput("t5_pre_valid", 64'(m_valid), 64'd1);
    #1 rst_n = 1'b0;
    expQ.delete();
    writeQ.delete();
    #1;
    checkOutput("t5_async_valid", 64'(m_valid), 64'd0);
    checkOutput("t5_async_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("t5_async_data", 64'(m_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    hsBase = handshakes;
    for (int i = 0; i < 3; i++) applyStimulus(fifo_word_t'(36'h600 + i));
    drainAll("t5", 50);
    checkOutput("t5_after_words", 64'(handshakes - hsBase), 64'd3);

`ifdef FIFO_READER_STATS_EN
    // Accepted-word counter and its wrap
    doReset();
    @(negedge clk);
    checkOutput("t6_count_rst", 64'(word_count), 64'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) applyStimulus(fifo_word_t'(36'h7000 + i));
    drainAll("t6", 1000);
    checkOutput("t6_count_300", 64'(word_count), 64'd300);
    @(posedge clk);
    #1 m_ready = 1'b0;
    force dut.stat_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.stat_count;
    @(negedge clk);
    checkOutput("t6_count_forced", 64'(word_count), 64'hFFFF_FFFF);
    @(posedge clk);
    #1 m_ready = 1'b1;
    applyStimulus(36'h8_0000_0001);
    drainAll("t6_wrap", 50);
    checkOutput("t6_count_wrap", 64'(word_count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
